ahb_conduit_panel_ctrl: RTL and testbench
=========================================

Name: ahb_conduit_panel_ctrl

Overview:
Board-side front panel for the AHB master/slave conduit of the PCIe/SDRAM system. Sits directly on the conduit. Drives the select and address inputs from a pushbutton and 16 slide switches. Consumes the returned 32-bit display word and shows it on eight active-low seven-segment digits. Includes input synchronisation, pushbutton debounce, a select toggle, and a rate-limited display snapshot.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles the key must be stable before a press or release is accepted (10 ms at 50 MHz)
REFRESH_CYCLES, 5000000, display snapshot period in cycles (10 Hz at 50 MHz)
ADDR_W, 16, conduit address width
DATA_W, 32, conduit display data width; fixed at 32 for eight digits

Ports:
clk_clk  in  1  system clock, same domain as the conduit
reset_reset  in  1  synchronous, active-high reset
key_n  in  1  pushbutton, active-low, asynchronous to clk_clk
sw  in  ADDR_W  slide switches, asynchronous
add_data_sel  out  1  conduit select: 0 = address mode, 1 = data mode
rdwr_address  out  ADDR_W  conduit read/write address
display_data  in  DATA_W  conduit return word
hex0..hex7  out  7 each  seven-segment digits, active-low, segment order {g,f,e,d,c,b,a}; hex0 = least significant nibble
led_mode  out  1  copy of add_data_sel for a board LED

Behaviour:
- One clock only. Reset is synchronous and active-high. All state is cleared on any clk_clk edge with reset_reset=1; reset mid-debounce or mid-refresh abandons that operation.
- Reset values: add_data_sel=0, led_mode=0, rdwr_address=0, snapshot register=0 so every hex digit shows "0" (7'b1000000), debounce FSM=IDLE, both counters=0.
- key_n and sw each pass through a 2-flop synchroniser. The synchroniser flops reset to key_n=1 and sw=0.
- Debounce FSM on the synchronised key (k):
  - IDLE: count cleared; k=0 -> PRESS_WAIT.
  - PRESS_WAIT: count++ while k=0; k=1 -> IDLE; count reaches DEBOUNCE_CYCLES-1 with k=0 -> HELD, and a one-cycle press pulse is generated.
  - HELD: k=1 -> RELEASE_WAIT.
  - RELEASE_WAIT: count++ while k=1; k=0 -> HELD; count reaches DEBOUNCE_CYCLES-1 -> IDLE.
  - Consequences: exactly one toggle per press however long it is held; glitches shorter than DEBOUNCE_CYCLES produce nothing.
- Press pulse toggles add_data_sel the following cycle. led_mode always equals add_data_sel.
- rdwr_address:
  - In address mode it loads the synchronised sw every cycle, giving 3 cycles of latency from the sw pin.
  - In data mode it is frozen at its last value.
- Refresh counter:
  - Free-runs 0..REFRESH_CYCLES-1 and wraps to 0.
  - The tick is asserted on the wrap cycle.
  - On a tick the snapshot register loads display_data in data mode, or {16'h0, rdwr_address} in address mode.
- Simultaneous tick and press pulse: the snapshot uses the mode value from before the toggle. The new mode takes effect at the next tick.
- hex digits are a pure decode of the registered snapshot nibbles (0-F, standard glyphs). Digits change only on the cycle after a tick.
- No combinational path from any input to any output.

Optional Feature:
BLANK_LEADING_ZEROS_EN
- Defined: any digit above the most significant non-zero nibble of the snapshot is blanked (7'b1111111). hex0 is never blanked, so snapshot 0 shows a single "0". Blanking is a decode of the registered snapshot and changes only after a tick.
- Undefined: all eight digits are always driven, leading zeros included.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8.
1. Reset -> add_data_sel=0, rdwr_address=0, all hex=7'b1000000; assert 3 cycles then release; values hold until the first tick.
2. sw=16'hBEEF in address mode -> rdwr_address=16'hBEEF 3 cycles later; after the next tick hex3..hex0 show B,E,E,F and hex7..hex4 show 0.
3. key_n low for 3 cycles then high -> no toggle. key_n low for 20 cycles -> add_data_sel goes to 1 exactly once; re-press after a 2-cycle release -> no toggle; re-press after a 6-cycle release -> add_data_sel returns to 0.
4. Data mode, display_data=32'h1234ABCD, then sw changed to 16'h0001 -> rdwr_address stays 16'hBEEF; after a tick hex7..hex0 show 1,2,3,4,A,B,C,D.
5. Press confirmed on the same cycle as a tick -> that snapshot still uses the old mode; the next tick uses the new mode. Reset asserted mid-PRESS_WAIT -> no toggle occurs after release.
6. With BLANK_LEADING_ZEROS_EN, snapshot 32'h000000A5 -> hex1=A, hex0=5, hex7..hex2=7'b1111111. Snapshot 0 -> only hex0 lit, showing "0".

Source files
------------

// File: rtl/ahb_conduit_panel_ctrl_if.sv
// Conduit signals between the front panel (master) and the AHB master/slave bridge (slave).
interface ahb_conduit_panel_ctrl_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
);
   logic              add_data_sel;
   logic [ADDR_W-1:0] rdwr_address;
   logic [DATA_W-1:0] display_data;

   modport master (
      output add_data_sel,
      output rdwr_address,
      input  display_data
   );

   modport slave (
      input  add_data_sel,
      input  rdwr_address,
      output display_data
   );
endinterface

// File: rtl/ahb_conduit_panel_ctrl.sv
// Front panel for the AHB conduit: key debounce toggles select, switches drive the address,
// and a rate-limited snapshot feeds eight seven-segment digits. Optional: BLANK_LEADING_ZEROS_EN.
module ahb_conduit_panel_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REFRESH_CYCLES  = 5000000,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned DATA_W          = 32
) (
   input  logic                     clk_clk,
   input  logic                     reset_reset,
   input  logic                     key_n,
   input  logic [ADDR_W-1:0]        sw,
   ahb_conduit_panel_ctrl_if.master conduit,
   output logic [6:0]               hex0,
   output logic [6:0]               hex1,
   output logic [6:0]               hex2,
   output logic [6:0]               hex3,
   output logic [6:0]               hex4,
   output logic [6:0]               hex5,
   output logic [6:0]               hex6,
   output logic [6:0]               hex7,
   output logic                     led_mode
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned REF_W = $clog2(REFRESH_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_RELEASE_WAIT
   } db_state_e;

   logic              key_s1_q, key_s1_d;
   logic              key_s2_q, key_s2_d;
   logic [ADDR_W-1:0] sw_s1_q, sw_s1_d;
   logic [ADDR_W-1:0] sw_s2_q, sw_s2_d;

   db_state_e         state_q, state_d;
   logic [DB_W-1:0]   count_q, count_d;
   logic              press_pulse;

   logic              sel_q, sel_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
   logic              ref_tick;
   logic [DATA_W-1:0] snap_q, snap_d;

   logic              k;
   logic [55:0]       hex_all;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // State register: every flop in the block, cleared synchronously
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         key_s1_q  <= 1'b1;
         key_s2_q  <= 1'b1;
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         state_q   <= ST_IDLE;
         count_q   <= '0;
         sel_q     <= 1'b0;
         addr_q    <= '0;
         ref_cnt_q <= '0;
         snap_q    <= '0;
      end else begin
         key_s1_q  <= key_s1_d;
         key_s2_q  <= key_s2_d;
         sw_s1_q   <= sw_s1_d;
         sw_s2_q   <= sw_s2_d;
         state_q   <= state_d;
         count_q   <= count_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         ref_cnt_q <= ref_cnt_d;
         snap_q    <= snap_d;
      end
   end

   always_comb begin
      key_s1_d = key_n;
      key_s2_d = key_s1_q;
      sw_s1_d  = sw;
      sw_s2_d  = sw_s1_q;
      k        = key_s2_q;
   end

   // Debounce next-state: the shared counter measures how long k has held its new level
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            count_d = '0;
            if (!k) state_d = ST_PRESS_WAIT;
         end
         ST_PRESS_WAIT: begin
            if (k) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (count_q == DB_LAST) begin
               state_d = ST_HELD;
               count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         ST_HELD: begin
            count_d = '0;
            if (k) state_d = ST_RELEASE_WAIT;
         end
         ST_RELEASE_WAIT: begin
            if (!k) begin
               state_d = ST_HELD;
               count_d = '0;
            end else if (count_q == DB_LAST) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_comb begin
      press_pulse = (state_q == ST_PRESS_WAIT) && !k && (count_q == DB_LAST);
   end

   // Snapshot samples the pre-toggle mode, so a coincident press only affects the next tick
   always_comb begin
      sel_d     = sel_q ^ press_pulse;
      addr_d    = sel_q ? addr_q : sw_s2_q;
      ref_tick  = (ref_cnt_q == REF_LAST);
      ref_cnt_d = ref_tick ? '0 : ref_cnt_q + 1'b1;
      snap_d    = snap_q;
      if (ref_tick) begin
         snap_d = sel_q ? conduit.display_data : DATA_W'(addr_q);
      end
   end

   always_comb begin
      hex_all = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         hex_all[7*i +: 7] = seg7(snap_q[4*i +: 4]);
`ifdef BLANK_LEADING_ZEROS_EN
         if (i != 0 && (snap_q >> (4*i)) == '0) begin
            hex_all[7*i +: 7] = '1;
         end
`endif
      end
   end

   always_comb begin
      conduit.add_data_sel = sel_q;
      conduit.rdwr_address = addr_q;
      led_mode             = sel_q;
      hex0 = hex_all[6:0];
      hex1 = hex_all[13:7];
      hex2 = hex_all[20:14];
      hex3 = hex_all[27:21];
      hex4 = hex_all[34:28];
      hex5 = hex_all[41:35];
      hex6 = hex_all[48:42];
      hex7 = hex_all[55:49];
   end

endmodule

// File: tb/tb_ahb_conduit_panel_ctrl.sv
// Bench for ahb_conduit_panel_ctrl: vector table, directed corner sequences and a random
// run, all checked against a behavioural model of the panel.
module tb_ahb_conduit_panel_ctrl;

   localparam int unsigned DEB = 4;
   localparam int unsigned REF = 8;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

`ifdef BLANK_LEADING_ZEROS_EN
   localparam logic [55:0] HEX_ZERO = {{7{7'h7F}}, 7'h40};
   localparam logic [55:0] HEX_ONE  = {{7{7'h7F}}, 7'h79};
`else
   localparam logic [55:0] HEX_ZERO = {8{7'h40}};
   localparam logic [55:0] HEX_ONE  = {{7{7'h40}}, 7'h79};
`endif
   localparam logic [55:0] HEX_DATA = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};

   logic        clk = 1'b0;
   logic        rst;
   logic        key_n;
   logic [15:0] sw;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic        led_mode;
   logic [55:0] dut_hex;

   ahb_conduit_panel_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ahb_conduit_panel_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .REFRESH_CYCLES (REF),
      .ADDR_W         (AW),
      .DATA_W         (DW)
   ) dut (
      .clk_clk    (clk),
      .reset_reset(rst),
      .key_n      (key_n),
      .sw         (sw),
      .conduit    (bus),
      .hex0       (hex0),
      .hex1       (hex1),
      .hex2       (hex2),
      .hex3       (hex3),
      .hex4       (hex4),
      .hex5       (hex5),
      .hex6       (hex6),
      .hex7       (hex7),
      .led_mode   (led_mode)
   );

   always #5 clk = ~clk;

   assign dut_hex = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [55:0] exp_hex(input logic [31:0] v);
      logic [55:0] r;
      logic [31:0] rest;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         rest = v >> (4*i);
         r[7*i +: 7] = GLYPH[rest[3:0]];
`ifdef BLANK_LEADING_ZEROS_EN
         if (i > 0 && rest == 32'h0) r[7*i +: 7] = 7'h7F;
`endif
      end
      return r;
   endfunction

   // Reference model: pin-sample delay lines, a "stable for DEB+1 samples" key filter,
   // a free cycle count for the refresh tick.
   logic        kp0, kp1;
   logic [15:0] sp0, sp1;
   logic        m_mode, m_pressed;
   logic [15:0] m_addr;
   logic [31:0] m_snap;
   int          m_run;
   int unsigned m_cyc;
   logic        mk, mpress, mdiffer, mtick;
   logic [15:0] ms;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         kp0 = 1'b1; kp1 = 1'b1; sp0 = '0; sp1 = '0;
         m_mode = 1'b0; m_pressed = 1'b0; m_addr = '0; m_snap = '0;
         m_run = 0; m_cyc = 0;
      end else begin
         mk = kp1;
         ms = sp1;
         mpress  = 1'b0;
         mdiffer = m_pressed ? (mk == 1'b1) : (mk == 1'b0);
         if (mdiffer) begin
            m_run++;
            if (m_run == int'(DEB) + 1) begin
               m_pressed = !m_pressed;
               m_run = 0;
               mpress = m_pressed;
            end
         end else begin
            m_run = 0;
         end
         mtick = ((m_cyc % REF) == REF - 1);
         m_cyc++;
         if (mtick) m_snap = m_mode ? bus.display_data : {16'h0, m_addr};
         if (!m_mode) m_addr = ms;
         if (mpress) m_mode = !m_mode;
         kp1 = kp0; kp0 = key_n;
         sp1 = sp0; sp0 = sw;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("mdl_sel",  64'(bus.add_data_sel), 64'(m_mode));
         chk("mdl_led",  64'(led_mode),         64'(m_mode));
         chk("mdl_addr", 64'(bus.rdwr_address), 64'(m_addr));
         chk("mdl_hex",  64'(dut_hex),          64'(exp_hex(m_snap)));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] swv;
      logic [55:0] hex_full;
      logic [55:0] hex_blank;
   } vec_t;

   vec_t vecs [6];
   int   key_hold;

   initial begin
      vecs[0] = '{16'h0906, {{5{7'h40}}, 7'h10, 7'h40, 7'h02}, {{5{7'h7F}}, 7'h10, 7'h40, 7'h02}};
      vecs[1] = '{16'h00A5, {{6{7'h40}}, 7'h08, 7'h12},        {{6{7'h7F}}, 7'h08, 7'h12}};
      vecs[2] = '{16'h0000, {8{7'h40}},                        {{7{7'h7F}}, 7'h40}};
      vecs[3] = '{16'h7310, {{4{7'h40}}, 7'h78, 7'h30, 7'h79, 7'h40}, {{4{7'h7F}}, 7'h78, 7'h30, 7'h79, 7'h40}};
      vecs[4] = '{16'h8C2D, {{4{7'h40}}, 7'h00, 7'h46, 7'h24, 7'h21}, {{4{7'h7F}}, 7'h00, 7'h46, 7'h24, 7'h21}};
      vecs[5] = '{16'hBEEF, {{4{7'h40}}, 7'h03, 7'h06, 7'h06, 7'h0E}, {{4{7'h7F}}, 7'h03, 7'h06, 7'h06, 7'h0E}};

      rst = 1'b1; key_n = 1'b1; sw = '0; bus.display_data = '0;
      cyc(1);
      chk_en = 1'b1;
      cyc(2);
      chk("rst_sel",  64'(bus.add_data_sel), 64'(0));
      chk("rst_addr", 64'(bus.rdwr_address), 64'(0));
      chk("rst_hex",  64'(dut_hex),          64'(HEX_ZERO));
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         chk("hold_hex", 64'(dut_hex), 64'(HEX_ZERO));
      end

      // Vector table in address mode: snapshot = {16'h0, sw}
      for (int i = 0; i < 6; i++) begin
         sw = vecs[i].swv;
         cyc(2 * REF);
         chk("vec_addr", 64'(bus.rdwr_address), 64'(vecs[i].swv));
`ifdef BLANK_LEADING_ZEROS_EN
         chk("vec_hex", 64'(dut_hex), 64'(vecs[i].hex_blank));
`else
         chk("vec_hex", 64'(dut_hex), 64'(vecs[i].hex_full));
`endif
      end

      sw = 16'h4321;
      cyc(2);
      chk("sw_lat2", 64'(bus.rdwr_address), 64'(16'hBEEF));
      cyc(1);
      chk("sw_lat3", 64'(bus.rdwr_address), 64'(16'h4321));
      sw = 16'hBEEF;
      cyc(4);

      key_n = 1'b0; cyc(3); key_n = 1'b1; cyc(10);
      chk("glitch_sel", 64'(bus.add_data_sel), 64'(0));
      key_n = 1'b0; cyc(20);
      chk("press_sel", 64'(bus.add_data_sel), 64'(1));
      key_n = 1'b1; cyc(2); key_n = 1'b0; cyc(12);
      chk("short_rel_sel", 64'(bus.add_data_sel), 64'(1));
      key_n = 1'b1; cyc(6); key_n = 1'b0; cyc(12);
      chk("repress_sel", 64'(bus.add_data_sel), 64'(0));
      key_n = 1'b1; cyc(10); key_n = 1'b0; cyc(12);
      chk("data_mode_sel", 64'(bus.add_data_sel), 64'(1));
      key_n = 1'b1; cyc(10);

      bus.display_data = 32'h1234ABCD;
      sw = 16'h0001;
      cyc(2 * REF);
      chk("data_addr", 64'(bus.rdwr_address), 64'(16'hBEEF));
      chk("data_hex",  64'(dut_hex),          64'(HEX_DATA));

      // Align a confirmed press with the 8th post-reset edge, which is also a tick
      rst = 1'b1; cyc(3); rst = 1'b0;
      cyc(1);
      key_n = 1'b0;
      cyc(6);
      chk("coinc_pre_sel", 64'(bus.add_data_sel), 64'(0));
      chk("coinc_pre_hex", 64'(dut_hex),          64'(HEX_ZERO));
      cyc(1);
      chk("coinc_sel", 64'(bus.add_data_sel), 64'(1));
      chk("coinc_hex", 64'(dut_hex),          64'(HEX_ONE));
      cyc(REF);
      chk("coinc_next_hex", 64'(dut_hex), 64'(HEX_DATA));

      key_n = 1'b1; cyc(10);
      key_n = 1'b0; cyc(4);
      rst = 1'b1; key_n = 1'b1; cyc(3); rst = 1'b0;
      cyc(20);
      chk("rst_pw_sel", 64'(bus.add_data_sel), 64'(0));

      key_hold = 0;
      for (int n = 0; n < 3000; n++) begin
         if (key_hold == 0) begin
            key_n = 1'($urandom_range(0, 1));
            key_hold = $urandom_range(1, 12);
         end
         key_hold--;
         if ($urandom_range(0, 9) == 0) sw = 16'($urandom >> $urandom_range(0, 31));
         if ($urandom_range(0, 4) == 0) bus.display_data = $urandom >> $urandom_range(0, 31);
         rst = ($urandom_range(0, 399) == 0);
         cyc(1);
      end
      rst = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
